// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage: FSM state encoding,
// datapath widths and the default reset PC.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  // Wide enough for any MAX_WAIT in 1..255.
  localparam int WAIT_W  = 8;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERR   = 2'd3
  } state_t;

endpackage

// File: rtl/fetch_if.sv
// -----------------------------------------------------------------------------
// fetch_if
// Instruction memory request/acknowledge bus.
//   imem_req   : fetch stage requests an instruction
//   imem_addr  : fetch address (current PC)
//   imem_ack   : memory accepted the request, imem_rdata valid this cycle
//   imem_rdata : instruction word
// master = fetch stage, slave = instruction memory.
// -----------------------------------------------------------------------------
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata
  );

endinterface

// File: rtl/next_pc_calc.sv
// -----------------------------------------------------------------------------
// next_pc_calc
// Purely combinational next-PC selection.
//   pc        in  current program counter
//   target    in  instr[25:0] (jump index; low 16 bits are the branch offset)
//   jump      in  jump resolved taken (highest priority)
//   branch    in  instruction is a branch
//   zero      in  ALU zero flag
//   pc_plus4  out pc + 4 (mod 2^32)
//   next_pc   out selected next PC
// -----------------------------------------------------------------------------
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [25:0]     target,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [PC_W-1:0] pc_plus4,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] jmp_target;

  assign pc_plus4   = pc + PC_W'(4);
  // Sign-extended word offset, already scaled by 4.
  assign br_offset  = {{(PC_W-18){target[15]}}, target[15:0], 2'b00};
  assign br_target  = pc_plus4 + br_offset;
  // Jump stays inside the current 256 MB region of pc_plus4.
  assign jmp_target = {pc_plus4[PC_W-1:PC_W-4], target, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jmp_target;
    end else if (branch && zero) begin
      next_pc = br_target;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: holds the PC, fetches over the imem bus, holds the
// instruction for execution and loads the resolved next PC on exec_done.
// A fetch that sees MAX_WAIT consecutive cycles without ack parks the block
// in ERR with a sticky fetch_err; only reset_n leaves ERR.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   halt                  stay in IDLE instead of starting a new fetch
//   bus (fetch_if.master) imem_req / imem_addr / imem_ack / imem_rdata
//   instr, op             latched instruction and its opcode field
//   instr_valid           instr is held for execution
//   exec_done             datapath finished; jump/branch/zero valid
//   jump, branch, zero    resolution inputs
//   pc_plus4              PC + 4 (link value)
//   fetch_err             sticky fetch timeout flag
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters:
//   instr_count           executed instructions (exec_done accepted)
//   wait_count            FETCH cycles without ack
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               halt,
  fetch_if.master            bus,
  output logic [INSTR_W-1:0] instr,
  output logic [5:0]         op,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               fetch_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        instr_count,
  output logic [31:0]        wait_count
`endif
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   next_pc;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fetch_hit;
  logic              fetch_miss;
  logic              timeout;
  logic              exec_accept;

  assign fetch_hit   = (state == ST_FETCH) && bus.imem_ack;
  assign fetch_miss  = (state == ST_FETCH) && !bus.imem_ack;
  // This miss is the MAX_WAIT-th consecutive one.
  assign timeout     = fetch_miss && (wait_cnt == WAIT_LAST);
  assign exec_accept = (state == ST_EXEC) && exec_done;

  next_pc_calc u_next_pc (
    .pc       (pc),
    .target   (instr[25:0]),
    .jump     (jump),
    .branch   (branch),
    .zero     (zero),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop
      // samples values from before the edge, independent of block order.
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first; any path that skipped an assignment would
    // otherwise infer a latch.
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (!halt) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ack) begin
          state_nxt = ST_EXEC;
        end else if (timeout) begin
          state_nxt = ST_ERR;
        end
      end
      ST_EXEC:  if (exec_done) state_nxt = halt ? ST_IDLE : ST_FETCH;
      ST_ERR:   state_nxt = ST_ERR;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs.
  always_comb begin
    bus.imem_req = (state == ST_FETCH);
    instr_valid  = (state == ST_EXEC);
  end

  assign bus.imem_addr = pc;
  assign op            = instr[31:26];

  // PC, instruction latch, wait counter and sticky error. Nothing changes in
  // ERR because none of the enables can be true there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc        <= RESET_PC;
      instr     <= '0;
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (fetch_hit)  instr     <= bus.imem_rdata;
      if (fetch_miss) wait_cnt  <= wait_cnt + WAIT_W'(1);
      if (timeout)    fetch_err <= 1'b1;
      if (exec_accept) begin
        pc       <= next_pc;
        wait_cnt <= '0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_count <= '0;
      wait_count  <= '0;
    end else begin
      if (exec_accept && (instr_count != '1)) instr_count <= instr_count + 32'd1;
      if (fetch_miss && (wait_count != '1))   wait_count  <= wait_count + 32'd1;
    end
  end
`endif

endmodule
